seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (at least 2).
REQ-003 Parameter HEX_MODE, default 0: 0 = BCD decode, 1 = hexadecimal decode.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 value_in  input  4*N_DIGITS  nibble per digit; digit k = bits [4k+3:4k], digit 0 least significant.
REQ-007 dp_in  input  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 load  input  1  capture value_in/dp_in into the shadow registers.
REQ-009 blank_lz  input  1  1 = suppress leading zeros.
REQ-010 seg_out  output  8  bit7 = dp, bits[6:0] = g..a; active-low (0 = lit); registered.
REQ-011 an_out  output  N_DIGITS  digit enables, active-low, at most one low at any time; registered.

Function
REQ-012 The block SHALL latch value_in and dp_in into shadow registers on every clk edge where load=1; the display SHALL use only the shadow registers.
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick = 1 on the cycle the count equals REFRESH_DIV-1.
REQ-014 On tick the digit index SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-015 In the cycle after a tick, an_out SHALL be all ones and seg_out 8'hFF (one-cycle anti-ghost blank).
REQ-016 In every other cycle, an_out SHALL drive bit [index] low and seg_out SHALL show the encoding of shadow digit [index].
REQ-017 Encoding (bit7 dp, bits 6..0): 0=1_1000000, 1=1_1111001, 2=1_0100100, 3=1_0110000, 4=1_0011001, 5=1_0010010, 6=1_0000010, 7=1_1111000, 8=1_0000000, 9=1_0010000.
REQ-018 With HEX_MODE=1: A=1_0001000, b=1_0000011, C=1_1000110, d=1_0100001, E=1_0000110, F=1_0001110.
REQ-019 With HEX_MODE=0, nibbles 10..15 SHALL encode as 1_1111111 (digit dark).
REQ-020 When a digit's shadow dp bit is 1, bit7 of seg_out SHALL be 0 while that digit is shown, including on a dark or blanked digit.
REQ-021 With blank_lz=1, a digit k>0 SHALL be dark (segments 1111111) when it and all higher digits are zero; digit 0 is never suppressed.
REQ-022 blank_lz SHALL be evaluated combinationally against the shadow registers; a change takes effect on the next registered output update.
REQ-023 A load coincident with a tick SHALL capture the new data, and the newly selected digit SHALL display the new data.
REQ-024 Output latency: seg_out/an_out SHALL reflect index and shadow state one clk after they change.

Reset
REQ-025 While rst=1 the block SHALL set prescaler=0, index=0, shadows=0, an_out all ones, seg_out=8'hFF; rst SHALL take priority over load.
REQ-026 Following rst deassertion, the first cycle SHALL display digit 0 and the first tick SHALL occur REFRESH_DIV cycles later.

Structure
REQ-027 The segment encoding constants and the blank pattern 8'hFF SHALL reside in a shared package, seg_pkg.
REQ-028 Nibble decoding SHALL be a sub-module, seg_decode (4-bit nibble + hex_mode + blank in, 7-bit segments out), instantiated once on the selected digit.

Verification
REQ-029 Use N_DIGITS=4 and REFRESH_DIV=4. Reset, then load 16'h1234 -> an_out cycles 1110,1101,1011,0111 with seg_out 1_0011001,1_0110000,1_0100100,1_1111001, and an all-ones blank cycle between slots.
REQ-030 With blank_lz=1, load 16'h0050 -> digits 3 and 2 dark, digit 1 shows 1_0010010, digit 0 shows 1_1000000; with blank_lz=0, digits 3 and 2 show 1_1000000.
REQ-031 With HEX_MODE=0, load 16'hABCD -> all digits 1_1111111. With HEX_MODE=1, same load -> d, C, b, A patterns.
REQ-032 Load 16'h0000 with dp_in=4'b0100 and blank_lz=1 -> digit 2 shows 0_1111111, digit 0 shows 1_1000000.
REQ-033 Assert rst mid-slot while index=2 -> on the next cycle an_out=1111 and seg_out=8'hFF; after release, digit 0 is shown for 4 cycles.
REQ-034 Pulse load in the tick cycle with a changed value -> the next displayed digit shows the new nibble; assert an_out is never all-ones except in blank and reset cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the scanned display driver.
// Segment patterns are active-low, bit order g..a.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_DARK  = 7'b1111111;

  // Index = nibble value; entries 10..15 are only used in hexadecimal mode.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low seven-segment decoder (g..a).
// Non-decimal nibbles go dark unless hex_mode is set; blank forces dark.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DARK;
    if (!blank && (hex_mode || (nibble <= 4'd9))) begin
      seg = SEG_FONT[nibble];
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: shadow registers, refresh prescaler,
// digit rotation with a one-cycle anti-ghost blank and leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int HEX_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out
);

  localparam int   CNT_W  = $clog2(REFRESH_DIV);
  localparam int   IDX_W  = $clog2(N_DIGITS);
  localparam logic HEX_EN = (HEX_MODE != 0);

  logic [CNT_W-1:0]      prescale;
  logic [IDX_W-1:0]      index;
  logic                  tick;
  logic [4*N_DIGITS-1:0] value_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [N_DIGITS-1:0]   lz_dark;
  logic                  higher_zero;
  logic [3:0]            sel_nibble;
  logic                  sel_dp;
  logic                  sel_dark;
  logic [6:0]            sel_seg;

  assign tick = (prescale == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      value_sh <= '0;
      dp_sh    <= '0;
    end else if (load) begin
      value_sh <= value_in;
      dp_sh    <= dp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      index    <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      if (tick) begin
        index <= (index == IDX_W'(N_DIGITS - 1)) ? '0 : index + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more significant digit is zero.
  always_comb begin
    lz_dark     = '0;
    higher_zero = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      higher_zero = higher_zero & (value_sh[4*k +: 4] == 4'd0);
      lz_dark[k]  = higher_zero;
    end
  end

  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_dark   = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (index == IDX_W'(k)) begin
        sel_nibble = value_sh[4*k +: 4];
        sel_dp     = dp_sh[k];
        sel_dark   = blank_lz & lz_dark[k];
      end
    end
  end

  seg_decode u_decode (
    .nibble   (sel_nibble),
    .hex_mode (HEX_EN),
    .blank    (sel_dark),
    .seg      (sel_seg)
  );

  // The tick cycle registers a blank so the next digit never ghosts the previous one.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      seg_out <= SEG_BLANK;
      an_out  <= '1;
    end else begin
      seg_out <= {~sel_dp, sel_seg};
      an_out  <= ~(N_DIGITS'(1) << index);
    end
  end

endmodule
